// File: rtl/truth_table_sweeper_if.sv
// ============================================================================
// truth_table_sweeper_if : control/status bundle between test controller and sweeper
// Revision 1.0
// ============================================================================
`default_nettype none

interface truth_table_sweeper_if;
   logic       start;
   logic [7:0] expected_tt;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] captured_tt;
   logic       fail_valid;
   logic [2:0] fail_index;

   modport master (
      output start,
      output expected_tt,
      input  busy,
      input  done,
      input  pass,
      input  captured_tt,
      input  fail_valid,
      input  fail_index
   );

   modport slave (
      input  start,
      input  expected_tt,
      output busy,
      output done,
      output pass,
      output captured_tt,
      output fail_valid,
      output fail_index
   );
endinterface

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper : walks a 3-input logic block through all 8 input codes
// and compares the measured truth table against an expected code. Revision 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   truth_table_sweeper_if.slave        ctrl,
   output logic [2:0]                  dut_in,
   input  logic                        dut_out
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   logic [1:0] state;
   logic [2:0] idx;
   logic [7:0] cnt;
   logic [7:0] exp_tt;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] captured_tt;
   logic       fail_valid;
   logic [2:0] fail_index;

   // Code bit 7 belongs to combination 000, bit 0 to combination 111.
   logic [2:0] bit_pos;
   logic       mismatch;

   assign bit_pos  = 3'd7 - idx;
   assign mismatch = (dut_out != exp_tt[bit_pos]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= 3'd0;
         cnt         <= 8'd0;
         exp_tt      <= 8'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         captured_tt <= 8'd0;
         fail_valid  <= 1'b0;
         fail_index  <= 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ctrl.start) begin
                  exp_tt      <= ctrl.expected_tt;
                  captured_tt <= 8'd0;
                  pass        <= 1'b0;
                  fail_valid  <= 1'b0;
                  fail_index  <= 3'd0;
                  idx         <= 3'd0;
                  cnt         <= 8'd0;
                  busy        <= 1'b1;
                  state       <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               cnt <= cnt + 8'd1;
               if (cnt == SETTLE_LAST) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               captured_tt[bit_pos] <= dut_out;
               if (mismatch && !fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_index <= idx;
               end
               if (idx != 3'd7) begin
                  idx   <= idx + 3'd1;
                  cnt   <= 8'd0;
                  state <= ST_SETTLE;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= !fail_valid && !mismatch;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The combination index doubles as the drive onto the logic block.
   assign dut_in           = idx;
   assign ctrl.busy        = busy;
   assign ctrl.done        = done;
   assign ctrl.pass        = pass;
   assign ctrl.captured_tt = captured_tt;
   assign ctrl.fail_valid  = fail_valid;
   assign ctrl.fail_index  = fail_index;

endmodule

`default_nettype wire
